// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//
// Shared definitions for the UART blocks (uart_tx today, uart_rx later).
//   - uart_tx_state_t : transmitter FSM state encoding
//   - UART_DEFAULT_CLKS_PER_BIT : 50 MHz / 115200 baud
//   - UART_DATA_BITS : data bits per frame
//   - even_parity() : XOR-reduce helper for the optional parity bit
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int unsigned UART_DEFAULT_CLKS_PER_BIT = 434;
    localparam int unsigned UART_DATA_BITS            = 8;

    // StParity is always present in the encoding so uart_rx can share the type,
    // even when the transmitter is built without parity.
    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
        StParity = 3'd3,
        StStop   = 3'd4
    } uart_tx_state_t;

    // Even parity: the parity bit makes the total count of ones even.
    function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
//
// 8N1 UART transmitter (8E1 when UART_TX_PARITY_EN is defined). Accepts one byte
// per tx_dv pulse while idle and shifts it out LSB-first: start bit, 8 data bits,
// optional even-parity bit, stop bit. Each bit lasts CLKS_PER_BIT clk cycles.
//
// Build option:
//   UART_TX_PARITY_EN - insert an even-parity bit between data and stop bits.
//
// Parameters:
//   CLKS_PER_BIT - clk cycles per UART bit, must be >= 2.
//
// Ports:
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset
//   tx_dv     in   single-cycle send request, ignored unless idle
//   tx_byte   in   byte to send, sampled in the tx_dv cycle
//   tx_active out  high while a frame is on the line
//   tx_serial out  UART line, idle high
//   tx_done   out  one-cycle pulse in the first idle cycle after a stop bit
//
// All outputs come straight from flops; their next values are derived from the
// next state so the line changes on the same edge as the state.
// -----------------------------------------------------------------------------
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_dv,
    input  logic [7:0] tx_byte,
    output logic       tx_active,
    output logic       tx_serial,
    output logic       tx_done
);

    localparam int unsigned CntW = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);
    localparam int unsigned IdxW = $clog2(UART_DATA_BITS);

    localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(UART_DATA_BITS - 1);

    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
            $error("uart_tx: CLKS_PER_BIT must be >= 2");
        end
    endgenerate

    uart_tx_state_t              state_q, state_d;
    logic [CntW-1:0]             clk_cnt_q, clk_cnt_d;
    logic [IdxW-1:0]             bit_idx_q, bit_idx_d;
    logic [UART_DATA_BITS-1:0]   shift_q, shift_d;
    logic                        tx_serial_q, tx_serial_d;
    logic                        tx_active_q, tx_active_d;
    logic                        tx_done_q, tx_done_d;
`ifdef UART_TX_PARITY_EN
    logic                        parity_q, parity_d;
`endif

    logic bit_end;
    assign bit_end = (clk_cnt_q == CntLast);

    // -------------------------------------------------------------------------
    // Next-state and registered-output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        clk_cnt_d   = clk_cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        tx_serial_d = tx_serial_q;
        tx_active_d = tx_active_q;
        tx_done_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d    = parity_q;
`endif

        unique case (state_q)
            StIdle: begin
                tx_serial_d = 1'b1;
                tx_active_d = 1'b0;
                if (tx_dv) begin
                    shift_d     = tx_byte;
                    clk_cnt_d   = '0;
                    bit_idx_d   = '0;
                    state_d     = StStart;
                    tx_serial_d = 1'b0;
                    tx_active_d = 1'b1;
`ifdef UART_TX_PARITY_EN
                    parity_d    = even_parity(tx_byte);
`endif
                end
            end

            StStart: begin
                if (bit_end) begin
                    clk_cnt_d   = '0;
                    state_d     = StData;
                    tx_serial_d = shift_q[0];
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end

            StData: begin
                if (bit_end) begin
                    clk_cnt_d = '0;
                    if (bit_idx_q == IdxLast) begin
`ifdef UART_TX_PARITY_EN
                        state_d     = StParity;
                        tx_serial_d = parity_q;
`else
                        state_d     = StStop;
                        tx_serial_d = 1'b1;
`endif
                    end else begin
                        // The line always shows shift_q[0]; the next bit is bit 1
                        // of the current register, which becomes bit 0 after the shift.
                        bit_idx_d   = bit_idx_q + 1'b1;
                        shift_d     = shift_q >> 1;
                        tx_serial_d = shift_q[1];
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end

`ifdef UART_TX_PARITY_EN
            StParity: begin
                if (bit_end) begin
                    clk_cnt_d   = '0;
                    state_d     = StStop;
                    tx_serial_d = 1'b1;
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
`endif

            StStop: begin
                tx_serial_d = 1'b1;
                if (bit_end) begin
                    clk_cnt_d   = '0;
                    bit_idx_d   = '0;
                    state_d     = StIdle;
                    tx_active_d = 1'b0;
                    tx_done_d   = 1'b1;
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end

            default: begin
                // Unreachable encodings (and StParity without parity) recover to idle.
                state_d     = StIdle;
                clk_cnt_d   = '0;
                bit_idx_d   = '0;
                tx_serial_d = 1'b1;
                tx_active_d = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            clk_cnt_q   <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            tx_serial_q <= 1'b1;
            tx_active_q <= 1'b0;
            tx_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            clk_cnt_q   <= clk_cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            tx_serial_q <= tx_serial_d;
            tx_active_q <= tx_active_d;
            tx_done_q   <= tx_done_d;
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end
`endif

    assign tx_serial = tx_serial_q;
    assign tx_active = tx_active_q;
    assign tx_done   = tx_done_q;

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx
//
// Directed bench for uart_tx with CLKS_PER_BIT = 4. Outputs are sampled 1 time
// unit after each rising edge. Expected line values come from exp_bit(), which
// builds the frame bit sequence directly from the byte.
// -----------------------------------------------------------------------------
module tb_uart_tx;

    localparam int unsigned Cpb = 4;
`ifdef UART_TX_PARITY_EN
    localparam int unsigned FrameBits = 11;
`else
    localparam int unsigned FrameBits = 10;
`endif
    localparam int unsigned FrameCycles = FrameBits * Cpb;

    logic       clk;
    logic       rst_n;
    logic       tx_dv;
    logic [7:0] tx_byte;
    logic       tx_active;
    logic       tx_serial;
    logic       tx_done;

    int tests_run = 0;
    int fails     = 0;

    uart_tx #(
        .CLKS_PER_BIT (Cpb)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tx_dv     (tx_dv),
        .tx_byte   (tx_byte),
        .tx_active (tx_active),
        .tx_serial (tx_serial),
        .tx_done   (tx_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic obs, input logic exp);
        tests_run++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Line level for frame bit position idx: start, data LSB-first, [parity], stop.
    function automatic logic exp_bit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
`ifdef UART_TX_PARITY_EN
        if (idx == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    task automatic check_idle(input string tag, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            check($sformatf("%s_serial_%0d", tag, i), tx_serial, 1'b1);
            check($sformatf("%s_active_%0d", tag, i), tx_active, 1'b0);
            check($sformatf("%s_done_%0d", tag, i), tx_done, 1'b0);
            tick();
        end
    endtask

    // Sends b starting in the current cycle and checks every frame cycle. If
    // inject_at > 0, a stray tx_dv with 0xFF is driven in that frame cycle.
    // Returns positioned in the tx_done cycle.
    task automatic send_frame(input logic [7:0] b, input int inject_at, input string tag);
        tx_byte = b;
        tx_dv   = 1'b1;
        tick();
        for (int n = 1; n <= int'(FrameCycles); n++) begin
            if (n == inject_at) begin
                tx_dv   = 1'b1;
                tx_byte = 8'hFF;
            end else begin
                tx_dv   = 1'b0;
                tx_byte = ~b;
            end
            check($sformatf("%s_serial_c%0d", tag, n), tx_serial, exp_bit(b, (n - 1) / Cpb));
            check($sformatf("%s_active_c%0d", tag, n), tx_active, 1'b1);
            check($sformatf("%s_done_c%0d", tag, n), tx_done, 1'b0);
            tick();
        end
        tx_dv = 1'b0;
        check($sformatf("%s_done_end", tag), tx_done, 1'b1);
        check($sformatf("%s_active_end", tag), tx_active, 1'b0);
        check($sformatf("%s_serial_end", tag), tx_serial, 1'b1);
    endtask

    initial begin
        rst_n   = 1'b0;
        tx_dv   = 1'b0;
        tx_byte = 8'h00;

        // Reset and idle
        tick();
        tick();
        check("rst_serial", tx_serial, 1'b1);
        check("rst_active", tx_active, 1'b0);
        check("rst_done", tx_done, 1'b0);
        rst_n = 1'b1;
        tick();
        check_idle("idle", 20);

        // Basic frame 0xA5
        send_frame(8'hA5, 0, "a5");
        tick();
        check("a5_done_single", tx_done, 1'b0);
        check_idle("a5_after", 4);

        // Request while busy must be dropped
        send_frame(8'h3C, 10, "3c");
        tick();
        check_idle("3c_after", FrameCycles + 4);

        // Back-to-back: second request lands in the tx_done cycle
        send_frame(8'h81, 0, "81");
        send_frame(8'h00, 0, "00");
        tick();
        check_idle("00_after", 4);

        // Asynchronous reset in the middle of the data bits of 0x55
        tx_byte = 8'h55;
        tx_dv   = 1'b1;
        tick();
        tx_dv   = 1'b0;
        for (int n = 1; n < 9; n++) tick();
        // Frame cycle 9 is data bit 1 of 0x55, which is 0
        check("rst55_serial_pre", tx_serial, 1'b0);
        check("rst55_active_pre", tx_active, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst55_serial_async", tx_serial, 1'b1);
        check("rst55_active_async", tx_active, 1'b0);
        check("rst55_done_async", tx_done, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        check_idle("rst55_after", FrameCycles + 4);
        send_frame(8'h55, 0, "55");
        tick();
        check_idle("55_after", 4);

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
